// File: rtl/fnd_scan_ctrl_if.sv
// Display bus for fnd_scan_ctrl: packed BCD/dp requests in, scanned common/segment drive out.
interface fnd_scan_ctrl_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] bcd_in;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   fnd_com;
   logic [7:0]          fnd_data;
   logic                frame_done;

   modport master (
      output bcd_in, dp_in,
      input  fnd_com, fnd_data, frame_done
   );

   modport slave (
      input  bcd_in, dp_in,
      output fnd_com, fnd_data, frame_done
   );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller with per-frame input snapshot (tear-free).
// Optional leading-zero blanking enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_ctrl #(
   parameter int unsigned DIGITS  = 4,
   parameter int unsigned CLK_DIV = 100000
) (
   input  logic               clk,
   input  logic               rst_n,
   fnd_scan_ctrl_if.slave     bus
);
   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned BCD_W = 4 * DIGITS;

   logic [CNT_W-1:0]  prescale_q, prescale_nxt;
   logic [IDX_W-1:0]  index_q, index_nxt;
   logic [BCD_W-1:0]  shadow_bcd_q;
   logic [DIGITS-1:0] shadow_dp_q;
   logic              upd_q;
   logic              frame_done_q;
   logic [DIGITS-1:0] fnd_com_q, com_nxt;
   logic [7:0]        fnd_data_q, data_nxt;
   logic              tick_c, wrap_c;
   logic [3:0]        cur_digit_c;
   logic              cur_dp_c;
   logic              cur_blank_c;

   // Active-low hex decode, bit order g..a.
   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      s = 7'h7F;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Prescaler, digit index and snapshot decision.
   always_comb begin
      tick_c       = (prescale_q == CNT_W'(CLK_DIV - 1));
      wrap_c       = tick_c && (index_q == IDX_W'(DIGITS - 1));
      prescale_nxt = tick_c ? '0 : prescale_q + CNT_W'(1);
      index_nxt    = index_q;
      if (tick_c) begin
         index_nxt = wrap_c ? '0 : index_q + IDX_W'(1);
      end
   end

   // Select the currently scanned digit from the shadow copy.
   always_comb begin
      cur_digit_c = 4'h0;
      cur_dp_c    = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (index_q == IDX_W'(k)) begin
            cur_digit_c = shadow_bcd_q[4*k +: 4];
            cur_dp_c    = shadow_dp_q[k];
         end
      end
   end

`ifdef FND_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_c;

   // A digit blanks when it and every higher digit are zero; digit 0 never blanks.
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      blank_c  = '0;
      for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
         all_zero   = all_zero & (shadow_bcd_q[4*k +: 4] == 4'h0);
         blank_c[k] = all_zero;
      end
   end

   always_comb begin
      cur_blank_c = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (index_q == IDX_W'(k)) cur_blank_c = blank_c[k];
      end
   end
`else
   always_comb begin
      cur_blank_c = 1'b0;
   end
`endif

   // Next output drive for the current index and shadow contents.
   always_comb begin
      com_nxt  = ~(DIGITS'(1) << index_q);
      data_nxt = {~cur_dp_c, cur_blank_c ? 7'h7F : seg7(cur_digit_c)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q   <= '0;
         index_q      <= IDX_W'(DIGITS - 1);
         shadow_bcd_q <= '0;
         shadow_dp_q  <= '0;
         upd_q        <= 1'b0;
         frame_done_q <= 1'b0;
         fnd_com_q    <= '1;
         fnd_data_q   <= 8'hFF;
      end else begin
         prescale_q   <= prescale_nxt;
         index_q      <= index_nxt;
         upd_q        <= tick_c;
         frame_done_q <= wrap_c;
         if (wrap_c) begin
            shadow_bcd_q <= bus.bcd_in;
            shadow_dp_q  <= bus.dp_in;
         end
         // Outputs follow one cycle after the tick so they see the new index/shadow.
         if (upd_q) begin
            fnd_com_q  <= com_nxt;
            fnd_data_q <= data_nxt;
         end
      end
   end

   assign bus.fnd_com    = fnd_com_q;
   assign bus.fnd_data   = fnd_data_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl (DIGITS=4, CLK_DIV=4); honours FND_LEADING_ZERO_BLANK_EN.
module tb_fnd_scan_ctrl;
   localparam int unsigned DIGITS  = 4;
   localparam int unsigned CLK_DIV = 4;
`ifdef FND_LEADING_ZERO_BLANK_EN
   localparam logic LZ = 1'b1;
`else
   localparam logic LZ = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [7:0] zero_hi;

   fnd_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

   fnd_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] com, input logic [7:0] data);
      check({tag, "_com"}, 8'(bus.fnd_com), 8'(com));
      check({tag, "_data"}, bus.fnd_data, data);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      zero_hi  = LZ ? 8'hFF : 8'hC0;
      rst_n    = 1'b0;
      bus.bcd_in = 16'h1234;
      bus.dp_in  = 4'b0000;

      tick(3);
      check_out("reset", 4'b1111, 8'hFF);
      check("reset_fd", 8'(bus.frame_done), 8'h00);

      @(negedge clk) rst_n = 1'b1;
      tick(3);
      check_out("pre_tick_blank", 4'b1111, 8'hFF);
      check("pre_tick_fd", 8'(bus.frame_done), 8'h00);
      tick(1);
      check("first_snap_fd", 8'(bus.frame_done), 8'h01);
      check_out("snap_still_blank", 4'b1111, 8'hFF);
      tick(1);
      check("fd_one_cycle", 8'(bus.frame_done), 8'h00);
      check_out("f1_d0", 4'b1110, 8'h99);
      tick(4);
      check_out("f1_d1", 4'b1101, 8'hB0);
      bus.bcd_in = 16'h5678;
      tick(4);
      check_out("f1_d2_no_tear", 4'b1011, 8'hA4);
      tick(4);
      check_out("f1_d3_no_tear", 4'b0111, 8'hF9);
      tick(3);
      check("f2_fd", 8'(bus.frame_done), 8'h01);
      check_out("f2_hold", 4'b0111, 8'hF9);
      tick(1);
      check_out("f2_d0", 4'b1110, 8'h80);
      bus.bcd_in = 16'h00AF;
      bus.dp_in  = 4'b0010;
      tick(4);
      check_out("f2_d1", 4'b1101, 8'hF8);
      tick(4);
      check_out("f2_d2", 4'b1011, 8'h82);
      tick(4);
      check_out("f2_d3", 4'b0111, 8'h92);

      tick(4);
      check_out("f3_d0_hexF", 4'b1110, 8'h8E);
      tick(4);
      check_out("f3_d1_A_dp", 4'b1101, 8'h08);
      bus.bcd_in = 16'h0000;
      bus.dp_in  = 4'b0000;
      tick(4);
      check_out("f3_d2_lz", 4'b1011, zero_hi);
      tick(4);
      check_out("f3_d3_lz", 4'b0111, zero_hi);

      tick(4);
      check_out("f4_d0_zero", 4'b1110, 8'hC0);
      tick(4);
      check_out("f4_d1_lz", 4'b1101, zero_hi);
      tick(4);
      check_out("f4_d2_lz", 4'b1011, zero_hi);
      tick(4);
      check_out("f4_d3_lz", 4'b0111, zero_hi);

      // Next snapshot lands 3 cycles from here, then every 16 cycles.
      for (int i = 1; i <= 48; i++) begin
         tick(1);
         check($sformatf("fd_period_%0d", i), 8'(bus.frame_done), ((i % 16) == 3) ? 8'h01 : 8'h00);
      end

      tick(12);
      check_out("pre_rst_d2", 4'b1011, zero_hi);
      bus.bcd_in = 16'h1234;
      @(negedge clk) rst_n = 1'b0;
      #1;
      check_out("async_rst", 4'b1111, 8'hFF);
      check("async_rst_fd", 8'(bus.frame_done), 8'h00);
      @(negedge clk) rst_n = 1'b1;
      tick(3);
      check_out("restart_blank", 4'b1111, 8'hFF);
      tick(1);
      check("restart_fd", 8'(bus.frame_done), 8'h01);
      tick(1);
      check_out("restart_d0", 4'b1110, 8'h99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
